data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the extra cycles between accepting a request and responding (range 0-15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder can accept a request this cycle.
REQ-007 SHALL have port RD  input  1  read request qualifier.
REQ-008 SHALL have port WR  input  1  write request qualifier.
REQ-009 SHALL have port DAddr  input  32  byte address.
REQ-010 SHALL have port DataIn  input  32  write data.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port DataOut  output  32  read data.
REQ-013 SHALL have port err  output  1  the response carries an error; valid only while resp_valid=1.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a cycle with req_valid=1, req_ready=1 and (RD|WR)=1, latching DAddr, DataIn, RD and WR.
REQ-017 SHALL ignore req_valid while RD=WR=0: no accept, no response, remain in IDLE.
REQ-018 On accept, SHALL load a wait counter with WAIT_CYCLES and enter BUSY, or enter RESP directly when WAIT_CYCLES=0.
REQ-019 In BUSY, SHALL decrement the counter each cycle and enter RESP on the cycle the counter reaches 1 before the decrement.
REQ-020 SHALL assert resp_valid for exactly one cycle in RESP, which occurs WAIT_CYCLES+1 cycles after the accept edge, then return to IDLE.
REQ-021 SHALL apply no response backpressure: resp_valid is never held.
REQ-022 SHALL report an error for any of these conditions: latched DAddr[1:0]!=0; latched DAddr[31:2]>=DEPTH_WORDS; RD=WR=1.
REQ-023 On an error, SHALL assert err=1 with resp_valid, make no memory access, and leave DataOut unchanged.
REQ-024 A valid write SHALL commit DataIn to word DAddr[31:2] on the edge entering RESP.
REQ-025 A valid read SHALL load DataOut on the edge entering RESP.
REQ-026 DataOut SHALL hold its value until the next valid read response.
REQ-027 SHALL force err=0 whenever resp_valid=0.
REQ-028 Requests presented in BUSY or RESP SHALL be neither accepted nor queued; the initiator must hold them until req_ready=1.
REQ-029 A read following a write to the same word SHALL return the newly written data.

Reset
REQ-030 Reset=1 SHALL force, on the next edge: state IDLE, req_ready=1, resp_valid=0, err=0, DataOut=0, wait counter 0, all memory words 0.
REQ-031 Reset SHALL take priority over all other activity, including mid-transaction; an in-flight write not yet committed is discarded and no response is issued.

Verification
REQ-032 Reset, then write DAddr=0x8, DataIn=0xDEADBEEF, WAIT_CYCLES=2 -> resp_valid high on cycle accept+3, err=0, req_ready low for cycles accept+1..accept+3.
REQ-033 Read DAddr=0x8 after REQ-032 -> resp_valid with DataOut=0xDEADBEEF, err=0; DataOut held at 0xDEADBEEF after the strobe.
REQ-034 Read DAddr=0x6 (misaligned) and read DAddr=0x100 with DEPTH_WORDS=64 -> err=1 on each response; DataOut unchanged; memory unchanged.
REQ-035 RD=WR=1 at DAddr=0x0 -> err=1 response; word 0 unchanged. RD=WR=0 with req_valid=1 -> no response for 10 cycles.
REQ-036 Assert Reset during BUSY of a write to 0x4 of 0x12345678 -> no resp_valid; a subsequent read of 0x4 returns 0x00000000.
REQ-037 WAIT_CYCLES=0, back-to-back requests held valid -> an accept every 2 cycles, resp_valid one cycle after each accept.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request port.
// Each accepted request gets exactly one response strobe after a fixed latency.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        RD,
  input  logic        WR,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic        resp_valid,
  output logic [31:0] DataOut,
  output logic        err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                         state;
  logic [3:0]                     wait_cnt;
  logic [31:0]                    addr_q;
  logic [31:0]                    data_q;
  logic                           rd_q;
  logic                           wr_q;
  logic [DEPTH_WORDS-1:0][31:0]   mem;

  logic                           accept;
  logic                           enter_resp;
  logic [31:0]                    src_addr;
  logic [31:0]                    src_data;
  logic                           src_rd;
  logic                           src_wr;
  logic                           src_err;
  logic [IDX_W-1:0]               src_idx;

  // With zero wait the access happens on the accept edge itself, so the
  // request is taken straight from the port rather than from the latches.
  always_comb begin
    accept     = (state == IDLE) && req_valid && (RD || WR);
    enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                 ((state == BUSY) && (wait_cnt == 4'd1));
    src_addr   = (state == IDLE) ? DAddr  : addr_q;
    src_data   = (state == IDLE) ? DataIn : data_q;
    src_rd     = (state == IDLE) ? RD     : rd_q;
    src_wr     = (state == IDLE) ? WR     : wr_q;
    src_err    = (src_addr[1:0] != 2'b00) ||
                 ({2'b00, src_addr[31:2]} >= 32'(DEPTH_WORDS)) ||
                 (src_rd && src_wr);
    src_idx    = src_addr[IDX_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      DataOut    <= '0;
      wait_cnt   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      mem        <= '0;
    end else begin
      resp_valid <= 1'b0;
      err        <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= DAddr;
            data_q    <= DataIn;
            rd_q      <= RD;
            wr_q      <= WR;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= BUSY;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        BUSY: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase

      // Erroneous requests still get a strobe but never touch memory or DataOut.
      if (enter_resp) begin
        resp_valid <= 1'b1;
        err        <= src_err;
        if (!src_err) begin
          if (src_wr) mem[src_idx] <= src_data;
          if (src_rd) DataOut <= mem[src_idx];
        end
      end
    end
  end

endmodule
